// File: rtl/alu_reg4.sv
// Registered integer ALU: ADD/SUB/MUL/AND/OR/XOR/SHL/CMP on zero-extended operands, latency 1.
// Optional macro ALU_FLAGS_EN adds registered flag_zero and flag_borrow outputs.
module alu_reg4 #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         op,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] result
`ifdef ALU_FLAGS_EN
  ,
  output logic               flag_zero,
  output logic               flag_borrow
`endif
);

  localparam int RW = 2 * WIDTH;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SHL = 3'b110,
    OP_CMP = 3'b111
  } op_e;

  op_e           opc;
  logic [RW-1:0] ax;
  logic [RW-1:0] bx;
  logic [RW-1:0] nxt;
  logic          a_lt_b;
  logic          a_eq_b;

  assign opc    = op_e'(op);
  assign ax     = {{WIDTH{1'b0}}, a};
  assign bx     = {{WIDTH{1'b0}}, b};
  assign a_lt_b = (a < b);
  assign a_eq_b = (a == b);

  // Shifting by an amount >= RW naturally yields zero.
  always_comb begin
    nxt = '0;
    case (opc)
      OP_ADD:  nxt = ax + bx;
      OP_SUB:  nxt = ax - bx;
      OP_MUL:  nxt = ax * bx;
      OP_AND:  nxt = ax & bx;
      OP_OR:   nxt = ax | bx;
      OP_XOR:  nxt = ax ^ bx;
      OP_SHL:  nxt = ax << b;
      OP_CMP:  nxt = {{(RW-2){1'b0}}, a_lt_b, a_eq_b};
      default: nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= nxt;
      end
    end
  end

`ifdef ALU_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_zero   <= 1'b0;
      flag_borrow <= 1'b0;
    end else if (in_valid) begin
      flag_zero   <= (nxt == '0);
      flag_borrow <= (opc == OP_SUB) && a_lt_b;
    end
  end
`endif

endmodule

// File: tb/tb_alu_reg4.sv
// Scoreboard testbench for alu_reg4: directed plan vectors plus randomized traffic
// checked against an arithmetic reference model. Define ALU_FLAGS_EN to also check flags.
module tb_alu_reg4;

  localparam int W  = 4;
  localparam int RW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [2:0]    op;
  logic          out_valid;
  logic [RW-1:0] result;
`ifdef ALU_FLAGS_EN
  logic          flag_zero;
  logic          flag_borrow;
`endif

  alu_reg4 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .result    (result)
`ifdef ALU_FLAGS_EN
    ,
    .flag_zero   (flag_zero),
    .flag_borrow (flag_borrow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] res;
    logic          fz;
    logic          fb;
    int            cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t last_exp;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc++;

  // Reference model: plain integer arithmetic reduced modulo 2^RW.
  function automatic exp_t model(int av, int bv, int opv);
    exp_t e;
    int   m = 1 << RW;
    int   r;
    case (opv)
      0: r = av + bv;
      1: r = (av - bv + m) % m;
      2: r = av * bv;
      3: r = av & bv;
      4: r = av | bv;
      5: r = av ^ bv;
      6: r = (bv >= RW) ? 0 : (av * (2 ** bv)) % m;
      default: r = ((av == bv) ? 1 : 0) + ((av < bv) ? 2 : 0);
    endcase
    r     = r % m;
    e.res = r[RW-1:0];
    e.fz  = (r == 0);
    e.fb  = (opv == 1) && (av < bv);
    e.cyc = 0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int av, input int bv, input int opv);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a        = av[W-1:0];
    b        = bv[W-1:0];
    op       = opv[2:0];
    e        = model(av, bv, opv);
    e.cyc    = cyc;
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = W'($urandom);
      b        = W'($urandom);
      op       = 3'($urandom);
    end
  endtask

  task automatic checkReset(input string name);
    checkOutput({name, "_result"}, int'(result), 0);
    checkOutput({name, "_valid"}, int'(out_valid), 0);
`ifdef ALU_FLAGS_EN
    checkOutput({name, "_fz"}, int'(flag_zero), 0);
    checkOutput({name, "_fb"}, int'(flag_borrow), 0);
`endif
  endtask

  // Monitor: pops one expectation per presented result; checks hold when idle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid === 1'b1) begin
        if (sbq.size() == 0 || sbq[0].cyc >= cyc) begin
          checkOutput("spurious_valid", int'(out_valid), 0);
        end else begin
          last_exp = sbq.pop_front();
          checkOutput("result", int'(result), int'(last_exp.res));
`ifdef ALU_FLAGS_EN
          checkOutput("flag_zero", int'(flag_zero), int'(last_exp.fz));
          checkOutput("flag_borrow", int'(flag_borrow), int'(last_exp.fb));
`endif
        end
      end else begin
        if (sbq.size() != 0 && sbq[0].cyc < cyc) begin
          checkOutput("missing_valid", int'(out_valid), 1);
          void'(sbq.pop_front());
        end
        checkOutput("hold_result", int'(result), int'(last_exp.res));
`ifdef ALU_FLAGS_EN
        checkOutput("hold_fz", int'(flag_zero), int'(last_exp.fz));
        checkOutput("hold_fb", int'(flag_borrow), int'(last_exp.fb));
`endif
      end
    end
  end

  task automatic clearModel();
    sbq.delete();
    last_exp.res = '0;
    last_exp.fz  = 1'b0;
    last_exp.fb  = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    op       = '0;
    clearModel();

    #3;
    checkReset("reset_initial");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);

    // ADD/SUB/MUL back to back
    applyStimulus(10, 9, 0);
    applyStimulus(10, 9, 1);
    applyStimulus(10, 9, 2);
    // extremes
    applyStimulus(15, 15, 2);
    applyStimulus(15, 15, 0);
    applyStimulus(3, 5, 1);
    // logic and shift
    applyStimulus(12, 10, 3);
    applyStimulus(12, 10, 4);
    applyStimulus(12, 10, 5);
    applyStimulus(15, 4, 6);
    applyStimulus(15, 9, 6);
    applyStimulus(15, 15, 6);
    applyStimulus(1, 7, 6);
    // compare
    applyStimulus(7, 7, 7);
    applyStimulus(2, 9, 7);
    applyStimulus(9, 2, 7);
    applyStimulus(5, 5, 1);
    applyStimulus(0, 0, 0);
    // hold after ADD
    applyStimulus(6, 7, 0);
    idle(3);

    // async reset mid-stream, after a result is presented
    applyStimulus(4, 3, 2);
    applyStimulus(8, 1, 0);
    @(posedge clk);
    #7;
    rst_n = 1'b0;
    #1;
    checkReset("reset_async");
    in_valid = 1'b0;
    clearModel();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // reset before the capture edge discards the pending result
    applyStimulus(9, 9, 0);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkReset("reset_pending");
    in_valid = 1'b0;
    clearModel();
    #2;
    rst_n = 1'b1;
    idle(2);

    // randomized traffic with random idle gaps
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3, 0) == 0) idle(1);
      applyStimulus(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
                    int'($urandom_range(7, 0)));
    end
    idle(4);
    checkOutput("queue_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_reg4.md
Name: alu_reg4

Overview:
- Small registered integer ALU: two unsigned WIDTH-bit operands, 3-bit opcode, 2*WIDTH-bit result.
- Arithmetic: add, subtract, multiply. Logic: AND, OR, XOR. Also left shift and unsigned compare.
- Result is registered, one cycle of latency, with a valid strobe.
- Used as a leaf datapath block beneath a controller that issues one operation per cycle.

Parameters:
- WIDTH, 4, operand width in bits; result width is 2*WIDTH. Legal range is 2 to 16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and opcode are valid this cycle
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- op  input  3  opcode
- out_valid  output  1  result holds a new value this cycle
- result  output  2*WIDTH  registered result

Behaviour:
- Reset: while rst_n=0, result=0 and out_valid=0, immediately and independent of clk. Reset asserted mid-operation discards the pending result.
- Capture: at a rising clk edge with in_valid=1, result <= f(op,a,b) and out_valid <= 1. The result is visible the cycle after issue (latency 1).
- No operation: at a rising edge with in_valid=0, out_valid <= 0 and result holds its previous value.
- Back-to-back operations: one operation per cycle. There is no backpressure and no stall.
- Operands a and b are zero-extended to 2*WIDTH before every operation. All arithmetic is modulo 2^(2*WIDTH).
- op 000 ADD: a+b. Never overflows.
- op 001 SUB: a-b, modulo 2^(2*WIDTH). If a<b, the result is the two's-complement negative value (e.g. 3-5 = 8'hFE for WIDTH=4).
- op 010 MUL: a*b, unsigned full product. Never overflows.
- op 011 AND: bitwise a&b, upper WIDTH bits 0.
- op 100 OR: bitwise a|b, upper WIDTH bits 0.
- op 101 XOR: bitwise a^b, upper WIDTH bits 0.
- op 110 SHL: zero-extended a shifted left by b.
  - Bits shifted past bit 2*WIDTH-1 are discarded.
  - A shift amount >= 2*WIDTH gives 0.
- op 111 CMP: result[0] = (a==b), result[1] = (a<b) unsigned, all other bits 0.
- Every opcode is defined; there is no illegal-op case.
- out_valid never asserts during reset, nor in the first cycle after reset release unless in_valid was 1 at that edge.

Optional Feature:
- Macro ALU_FLAGS_EN.
- When defined, the block adds two registered outputs, updated under the same capture rule as result, reset to 0, and holding when in_valid=0:
  - flag_zero (1 bit): next result == 0.
  - flag_borrow (1 bit): 1 only for op SUB with a<b, else 0.
- When undefined, these ports and their registers do not exist. All other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 between clock edges -> result=0, out_valid=0 immediately. Release reset, in_valid=0 -> outputs stay 0.
- a=10, b=9, WIDTH=4, issue ADD, SUB, MUL on consecutive cycles with in_valid=1 -> results 19, 1, 90 on the three following cycles, out_valid=1 each cycle.
- Extremes: a=15, b=15: MUL -> 225; ADD -> 30. a=3, b=5: SUB -> 8'hFE (flag_borrow=1 if ALU_FLAGS_EN).
- Logic and shift: a=4'b1100, b=4'b1010: AND -> 8, OR -> 14, XOR -> 6. a=15, SHL with b=4 -> 8'hF0; b=9 -> 0.
- CMP: a=7, b=7 -> 1; a=2, b=9 -> 2; a=9, b=2 -> 0.
- Hold and async reset: in_valid=0 after an ADD -> result holds, out_valid=0. Drop rst_n mid-stream -> result and out_valid go to 0 without waiting for a clock edge. With ALU_FLAGS_EN, a=5, b=5 SUB -> flag_zero=1, flag_borrow=0.
